uart_tx_buffer: RTL and testbench

- Transmit-side byte FIFO and launch controller that sits directly upstream of the UART transmitter.
- Accepts bytes from the host/bus side and drives the transmitter's tx_start/din handshake, one byte at a time.
- Waits for the transmitter's tx_done_tick before launching the next byte, so the host never has to track serial timing.

---
 rtl/uart_tx_buffer_pkg.sv | 14 +
 rtl/uart_tx_buffer_if.sv | 32 +++
 rtl/uart_tx_buffer_fifo.sv | 62 ++++++
 rtl/uart_tx_buffer.sv | 75 +++++++
 tb/tb_uart_tx_buffer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the UART transmit buffer: default widths/depths and
// the launch FSM state type.
package uart_tx_buffer_pkg;

    localparam int unsigned DBIT_DEF   = 8;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned ADDR_W_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Host/transmitter-facing signal bundle of the UART transmit buffer.
// master = host side (drives writes and tx_done_tick), slave = the buffer.
interface uart_tx_buffer_if
    import uart_tx_buffer_pkg::*;
#(
    parameter int unsigned DBIT   = DBIT_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic              wr_en;
    logic [DBIT-1:0]   wr_data;
    logic              ovf_clr;
    logic              tx_done_tick;
    logic              tx_start;
    logic [DBIT-1:0]   tx_din;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              overflow;

    modport master (
        output wr_en, wr_data, ovf_clr, tx_done_tick,
        input  tx_start, tx_din, full, empty, count, busy, overflow
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr, tx_done_tick,
        output tx_start, tx_din, full, empty, count, busy, overflow
    );

endinterface

// File: rtl/uart_tx_buffer_fifo.sv
// Generic synchronous FIFO with registered occupancy count; full/empty are
// decoded from the count. Usable on both the transmit and receive side.
module uart_fifo
    import uart_tx_buffer_pkg::*;
#(
    parameter int unsigned DBIT   = DBIT_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    input  logic              rd_en,
    output logic [DBIT-1:0]   rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;

    always_comb begin
        push = wr_en && !full;
        pop  = rd_en && !empty;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit byte FIFO plus launch controller: pops one byte at a time into the
// UART transmitter and waits for tx_done_tick before launching the next.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int unsigned DBIT   = DBIT_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    uart_tx_buffer_if.slave bus
);

    tx_state_t        state;
    tx_state_t        state_next;
    logic             launch;
    logic [DBIT-1:0]  head;

    uart_fifo #(
        .DBIT   (DBIT),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (launch),
        .rd_data (head),
        .full    (bus.full),
        .empty   (bus.empty),
        .count   (bus.count)
    );

    // tx_start and tx_din are registered alongside the state so the launch
    // pulse lines up with the first WAIT cycle and tx_din holds afterwards.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            bus.tx_start <= 1'b0;
            bus.tx_din   <= '0;
        end else begin
            state        <= state_next;
            bus.tx_start <= launch;
            if (launch)
                bus.tx_din <= head;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch)           state_next = WAIT;
            WAIT:    if (bus.tx_done_tick) state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_comb begin
        launch   = (state == IDLE) && !bus.empty;
        bus.busy = (state == WAIT);
    end

    // A dropped write sets the flag even when a clear arrives the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n)
            bus.overflow <= 1'b0;
        else if (bus.wr_en && bus.full)
            bus.overflow <= 1'b1;
        else if (bus.ovf_clr)
            bus.overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: a queue/counter reference model
// predicts flags and launch timing, a negedge monitor checks every cycle.
module tb_uart_tx_buffer;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_buffer_if #(.DBIT(8), .ADDR_W(4)) bus ();

    uart_tx_buffer #(
        .DBIT   (8),
        .DEPTH  (DEPTH),
        .ADDR_W (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    bit mon_en   = 1'b0;

    // Reference model state: occupancy, busy, overflow, expected launch.
    int         mcount = 0;
    bit         mbusy  = 1'b0;
    bit         movf   = 1'b0;
    bit         mstart = 1'b0;
    bit         m_full, m_pop, m_wr;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            mcount = 0;
            mbusy  = 1'b0;
            movf   = 1'b0;
            mstart = 1'b0;
            exp_q.delete();
        end else begin
            m_full = (mcount == DEPTH);
            m_pop  = !mbusy && (mcount > 0);
            m_wr   = bus.wr_en && !m_full;
            if (m_wr)
                exp_q.push_back(bus.wr_data);
            mcount = mcount + int'(m_wr) - int'(m_pop);
            if (bus.wr_en && m_full)
                movf = 1'b1;
            else if (bus.ovf_clr)
                movf = 1'b0;
            mstart = m_pop;
            if (m_pop)
                mbusy = 1'b1;
            else if (mbusy && bus.tx_done_tick)
                mbusy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", bus.count, mcount);
            chk("full", bus.full, mcount == DEPTH);
            chk("empty", bus.empty, mcount == 0);
            chk("busy", bus.busy, mbusy);
            chk("overflow", bus.overflow, movf);
            chk("tx_start", bus.tx_start, mstart);
            chk("count_le_depth", 32'(bus.count <= 5'd16), 32'd1);
            if (bus.tx_start === 1'b1) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: actual=launch required=no launch at %0t", $time);
                end else begin
                    chk("tx_din", bus.tx_din, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 60; i++) begin
            if (bus.tx_start === 1'b1)
                return;
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_start: actual=timeout required=tx_start at %0t", $time);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (bus.count == 0 && bus.busy == 1'b0)
                break;
            bus.tx_done_tick = bus.busy;
            step();
            bus.tx_done_tick = 1'b0;
        end
        chk("drain_count", bus.count, 0);
        chk("drain_busy", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int next;
        bus.wr_en        = 1'b0;
        bus.wr_data      = '0;
        bus.ovf_clr      = 1'b0;
        bus.tx_done_tick = 1'b0;

        // Reset values
        step();
        step();
        mon_en = 1'b1;
        step();
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_din", bus.tx_din, 0);
        reset_n = 1'b1;
        step();

        // Single byte: launch two cycles after the write
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        step();
        bus.wr_en = 1'b0;
        chk("t1_no_start_yet", bus.tx_start, 0);
        chk("t1_not_empty", bus.empty, 0);
        step();
        chk("t1_start", bus.tx_start, 1);
        chk("t1_din", bus.tx_din, 8'hA5);
        step();
        chk("t1_pulse_one_cycle", bus.tx_start, 0);
        chk("t1_busy", bus.busy, 1);
        repeat (5) step();
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        chk("t1_idle", bus.busy, 0);
        chk("t1_empty", bus.empty, 1);
        chk("t1_din_held", bus.tx_din, 8'hA5);

        // Ordering with done 20 cycles after each launch
        s0 = n_starts;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h11 * (i + 1));
            step();
        end
        bus.wr_en = 1'b0;
        repeat (18) step();
        bus.tx_done_tick = 1'b1; step(); bus.tx_done_tick = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_start();
            repeat (19) step();
            bus.tx_done_tick = 1'b1; step(); bus.tx_done_tick = 1'b0;
        end
        repeat (10) step();
        chk("t2_pulses", n_starts - s0, 3);
        chk("t2_empty", bus.empty, 1);

        // Fill to full and overflow
        for (int i = 0; i < 18; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i);
            step();
        end
        bus.wr_en = 1'b0;
        chk("t3_count16", bus.count, 16);
        chk("t3_full", bus.full, 1);
        chk("t3_ovf", bus.overflow, 1);
        bus.ovf_clr = 1'b1; step(); bus.ovf_clr = 1'b0;
        chk("t3_ovf_clr", bus.overflow, 0);
        chk("t3_count_kept", bus.count, 16);

        // Write while full with a pop on the same edge: still dropped
        bus.tx_done_tick = 1'b1; step(); bus.tx_done_tick = 1'b0;
        bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
        step();
        bus.wr_en = 1'b0;
        chk("t3_pushpop_full_ovf", bus.overflow, 1);
        chk("t3_pushpop_full_count", bus.count, 15);
        chk("t3_next_din", bus.tx_din, 8'h01);
        bus.ovf_clr = 1'b1; step(); bus.ovf_clr = 1'b0;
        drain();

        // Push and pop on the same edge with count 5
        for (int i = 0; i < 6; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h40 + i);
            step();
        end
        bus.wr_en = 1'b0;
        step();
        chk("t5_count5", bus.count, 5);
        bus.tx_done_tick = 1'b1; step(); bus.tx_done_tick = 1'b0;
        bus.wr_en = 1'b1; bus.wr_data = 8'h4F;
        step();
        bus.wr_en = 1'b0;
        chk("t5_pushpop_count", bus.count, 5);
        chk("t5_pushpop_start", bus.tx_start, 1);
        drain();

        // Wrap-around: 40 sequential bytes, never written while full
        s0 = n_starts;
        next = 0;
        for (int c = 0; c < 3000 && next < 40; c++) begin
            bus.wr_en = (mcount < DEPTH) && ($urandom_range(0, 1) == 1);
            bus.wr_data = 8'(next);
            if (bus.wr_en)
                next++;
            bus.tx_done_tick = ($urandom_range(0, 5) == 0);
            step();
        end
        bus.wr_en = 1'b0;
        bus.tx_done_tick = 1'b0;
        drain();
        chk("t4_written", next, 40);
        chk("t4_launches", n_starts - s0, 40);
        chk("t4_sb_empty", exp_q.size(), 0);

        // Random soak including overflow and clears
        for (int c = 0; c < 1500; c++) begin
            bus.wr_en        = ($urandom_range(0, 1) == 1);
            bus.wr_data      = 8'($urandom);
            bus.ovf_clr      = ($urandom_range(0, 15) == 0);
            bus.tx_done_tick = ($urandom_range(0, 3) == 0);
            step();
        end
        bus.wr_en = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.tx_done_tick = 1'b0;
        drain();
        bus.ovf_clr = 1'b1; step(); bus.ovf_clr = 1'b0;

        // Reset with 4 bytes queued and one in flight
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'hB0 + i);
            step();
        end
        bus.wr_en = 1'b0;
        chk("t6_count4", bus.count, 4);
        chk("t6_busy", bus.busy, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t6_count", bus.count, 0);
        chk("t6_empty", bus.empty, 1);
        chk("t6_busy0", bus.busy, 0);
        chk("t6_tx_start", bus.tx_start, 0);
        chk("t6_ovf", bus.overflow, 0);
        s0 = n_starts;
        repeat (20) step();
        chk("t6_no_start", n_starts - s0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
